// File: rtl/mrd_pkg.sv
// Shared constants and types for the mixed-radix bank write crossbar.
// Optional build macro: MRD_BANK_WR_PARITY_EN (parity bit on wr_data).
package mrd_pkg;

  localparam int N_LANE = 5;
  localparam int W_DATA = 18;
  localparam int W_ADDR = 8;
  localparam int W_IDX  = 3;
  localparam int W_CNT  = 12;

  // radix encodings carried on in_factor
  localparam logic [2:0] FACT_R2 = 3'd2;
  localparam logic [2:0] FACT_R3 = 3'd3;
  localparam logic [2:0] FACT_R4 = 3'd4;
  localparam logic [2:0] FACT_R5 = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // sticky error bit positions
  localparam int ERR_CONFLICT = 0;
  localparam int ERR_INDEX    = 1;
  localparam int ERR_PROTO    = 2;

  // number of active lanes for a radix; unknown radix activates nothing
  function automatic logic [2:0] lane_cnt(input logic [2:0] factor);
    case (factor)
      FACT_R2, FACT_R3, FACT_R4, FACT_R5: return factor;
      default:                            return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mrd_bank_sel.sv
// Per-bank lane selector: lowest-numbered active lane targeting BANK wins,
// any further hit on the same bank is reported as a conflict.
module mrd_bank_sel #(
  parameter int N_LANE = mrd_pkg::N_LANE,
  parameter int W_IDX  = mrd_pkg::W_IDX,
  parameter int BANK   = 0
) (
  input  logic [N_LANE-1:0]       act,
  input  logic [N_LANE*W_IDX-1:0] idx,
  output logic [N_LANE-1:0]       sel,
  output logic                    hit,
  output logic                    conflict
);

  // priority encode over lanes, flag second and later matches
  always_comb begin
    sel      = '0;
    hit      = 1'b0;
    conflict = 1'b0;
    for (int l = 0; l < N_LANE; l++) begin
      if (act[l] && (idx[l*W_IDX +: W_IDX] == W_IDX'(BANK))) begin
        if (hit) conflict = 1'b1;
        else begin
          sel[l] = 1'b1;
          hit    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mrd_bank_wr_xbar.sv
// Write-back crossbar of the butterfly/twiddle stage: routes each active
// lane to its memory bank two cycles after the beat, tracks beats per stage,
// latches the block exponent and keeps sticky conflict/protocol flags.
// Optional build macro: MRD_BANK_WR_PARITY_EN adds an even-parity MSB to
// every wr_data word.
module mrd_bank_wr_xbar #(
  parameter int N_LANE = mrd_pkg::N_LANE,
  parameter int W_DATA = mrd_pkg::W_DATA,
  parameter int W_ADDR = mrd_pkg::W_ADDR,
  parameter int W_IDX  = mrd_pkg::W_IDX,
  parameter int W_CNT  = mrd_pkg::W_CNT,
`ifdef MRD_BANK_WR_PARITY_EN
  localparam int W_WR  = 2*W_DATA + 1
`else
  localparam int W_WR  = 2*W_DATA
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sop,
  input  logic [W_CNT-1:0]           n_beats,
  input  logic                       in_valid,
  input  logic [2:0]                 in_factor,
  input  logic [N_LANE*W_DATA-1:0]   in_real,
  input  logic [N_LANE*W_DATA-1:0]   in_imag,
  input  logic [N_LANE*W_IDX-1:0]    in_bank_index,
  input  logic [N_LANE*W_ADDR-1:0]   in_bank_addr,
  input  logic [3:0]                 in_exp,
  output logic [N_LANE-1:0]          wr_en,
  output logic [N_LANE*W_ADDR-1:0]   wr_addr,
  output logic [N_LANE*W_WR-1:0]     wr_data,
  output logic [3:0]                 exp_out,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 err
);
  import mrd_pkg::*;

  localparam logic [2:0] PROTO_M = 3'b1 << ERR_PROTO;

  // ---------------- S1: input registers ----------------
  logic                      s1_vld;
  logic [2:0]                s1_factor;
  logic [N_LANE*W_DATA-1:0]  s1_re, s1_im;
  logic [N_LANE*W_IDX-1:0]   s1_idx;
  logic [N_LANE*W_ADDR-1:0]  s1_addr;

  // capture the beat; reset kills any beat in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_factor <= '0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_idx    <= '0;
      s1_addr   <= '0;
    end else begin
      s1_vld    <= in_valid;
      s1_factor <= in_factor;
      s1_re     <= in_real;
      s1_im     <= in_imag;
      s1_idx    <= in_bank_index;
      s1_addr   <= in_bank_addr;
    end
  end

  // ---------------- S2: crossbar ----------------
  logic [N_LANE-1:0]              act, lane_ok, hit, conf;
  logic [N_LANE-1:0][N_LANE-1:0]  sel;
  logic [2:0]                     nl;
  logic [2:0]                     xb_err;

  // lane activity from radix; out-of-range indices never reach a bank
  always_comb begin
    nl     = lane_cnt(s1_factor);
    xb_err = '0;
    for (int l = 0; l < N_LANE; l++) begin
      act[l]     = s1_vld && (l < int'(nl));
      lane_ok[l] = act[l] && (s1_idx[l*W_IDX +: W_IDX] < W_IDX'(N_LANE));
    end
    xb_err[ERR_CONFLICT] = |conf;
    xb_err[ERR_INDEX]    = |(act & ~lane_ok);
  end

  for (genvar b = 0; b < N_LANE; b++) begin : g_bank
    mrd_bank_sel #(.N_LANE(N_LANE), .W_IDX(W_IDX), .BANK(b)) u_sel (
      .act      (lane_ok),
      .idx      (s1_idx),
      .sel      (sel[b]),
      .hit      (hit[b]),
      .conflict (conf[b])
    );
  end

  logic [N_LANE-1:0][W_ADDR-1:0]   addr_mx;
  logic [N_LANE-1:0][2*W_DATA-1:0] data_mx;
  logic [N_LANE-1:0][W_WR-1:0]     wd;

  // one-hot AND-OR mux of the winning lane onto each bank
  always_comb begin
    for (int b = 0; b < N_LANE; b++) begin
      addr_mx[b] = '0;
      data_mx[b] = '0;
      for (int l = 0; l < N_LANE; l++) begin
        if (sel[b][l]) begin
          addr_mx[b] = s1_addr[l*W_ADDR +: W_ADDR];
          data_mx[b] = {s1_re[l*W_DATA +: W_DATA], s1_im[l*W_DATA +: W_DATA]};
        end
      end
`ifdef MRD_BANK_WR_PARITY_EN
      wd[b] = {^data_mx[b], data_mx[b]};
`else
      wd[b] = data_mx[b];
`endif
    end
  end

  // register the bank write ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= hit;
      wr_addr <= addr_mx;
      wr_data <= wd;
    end
  end

  // ---------------- stage control ----------------
  state_t            state;
  logic [W_CNT-1:0]  cnt, n_lat;
  logic              flush_cnt;

  // stage FSM: beat counting, exponent capture, drain, done pulse, errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      flush_cnt <= 1'b0;
      exp_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
    end else begin
      done <= 1'b0;
      if (sop) begin
        // restart; a beat arriving with sop is beat 0 of the new stage
        busy      <= 1'b1;
        n_lat     <= n_beats;
        flush_cnt <= 1'b0;
        err       <= xb_err | (((state == RUN) || (state == FLUSH)) ? PROTO_M : 3'b0);
        if (in_valid && (n_beats == W_CNT'(1))) begin
          cnt     <= W_CNT'(1);
          exp_out <= in_exp;
          state   <= FLUSH;
        end else begin
          cnt   <= in_valid ? W_CNT'(1) : '0;
          state <= RUN;
        end
      end else begin
        case (state)
          IDLE, DONE: begin
            err   <= err | xb_err | (in_valid ? PROTO_M : 3'b0);
            state <= IDLE;
          end
          RUN: begin
            err <= err | xb_err;
            if (in_valid) begin
              cnt <= cnt + W_CNT'(1);
              if (cnt == n_lat - W_CNT'(1)) begin
                exp_out   <= in_exp;
                flush_cnt <= 1'b0;
                state     <= FLUSH;
              end
            end
          end
          FLUSH: begin
            err       <= err | xb_err;
            flush_cnt <= 1'b1;
            if (flush_cnt) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mrd_bank_wr_xbar.md
Name: mrd_bank_wr_xbar

Overview:
- Write-back end of the radix-2/3/4/5 butterfly/twiddle stage. It consumes the per-beat stage result (5 complex lanes, each tagged with a bank index and bank address) and routes each lane onto the write port of the matching memory bank through a crossbar.
- Counts the beats in each stage, captures the block exponent, and flags bank conflicts and protocol errors.
- Reports stage completion to the mixed-radix sequencer.

Parameters:
- N_LANE, 5, number of lanes and number of banks
- W_DATA, 18, real or imag sample width (signed)
- W_ADDR, 8, bank address width
- W_IDX, 3, bank index width
- W_CNT, 12, beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sop  in  1  stage start pulse; arms the block and clears the beat counter
- n_beats  in  W_CNT  expected beats this stage; sampled on sop; 0 is illegal
- in_valid  in  1  beat strobe from the twiddle output
- in_factor  in  3  radix of the current stage (2..5)
- in_real  in  N_LANE×W_DATA  lane real parts
- in_imag  in  N_LANE×W_DATA  lane imag parts
- in_bank_index  in  N_LANE×W_IDX  destination bank per lane
- in_bank_addr  in  N_LANE×W_ADDR  destination address per lane
- in_exp  in  4  block exponent accompanying the stage
- wr_en  out  N_LANE  per-bank write enable
- wr_addr  out  N_LANE×W_ADDR  per-bank address
- wr_data  out  N_LANE×2W_DATA  per-bank data, {real,imag}
- exp_out  out  4  exponent of the last completed stage
- busy  out  1  high from sop until done
- done  out  1  one-cycle pulse at stage completion
- err  out  3  sticky: [0] bank conflict, [1] index>4, [2] sop while RUN or beat while IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Active lanes by in_factor: 2 → lanes 0-1; 3 → lanes 0-2; 4 → lanes 0-3; 5 → lanes 0-4. Any other factor → no lanes active. Inactive lanes are never written.
- Pipeline (2 cycles):
  - S1 registers all inputs.
  - S2 runs the crossbar and registers the outputs.
  - A beat sampled at edge t drives wr_* at t+2.
- Crossbar, per bank b:
  - The lowest-numbered active lane with index==b wins and drives wr_en[b], wr_addr[b], wr_data[b].
  - Two or more active lanes hitting b in one beat → err[0] set; the losing lanes are dropped.
  - An active lane with index>4 → lane dropped, err[1] set.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: sop → RUN. cnt=0, latch n_beats, clear err, busy=1.
  - RUN: each in_valid increments cnt. When cnt reaches n_beats-1 with in_valid, latch in_exp into exp_out → FLUSH.
  - FLUSH: wait 2 cycles for the pipeline to drain → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Simultaneous events:
  - sop in RUN/FLUSH: restart as from IDLE (err cleared, then err[2] set). Beats still in flight are still written.
  - in_valid in IDLE or DONE: beat is not counted, is still routed to the banks, and sets err[2].
  - sop and in_valid in the same cycle: the beat counts as beat 0 of the new stage.
- Counter width: cnt is W_CNT bits and never wraps inside a stage, since n_beats < 2^W_CNT.
- Asynchronous reset mid-stage: pipeline registers, wr_en, busy and done clear immediately; no partial write is issued after reset.

Optional Feature:
- Macro: MRD_BANK_WR_PARITY_EN.
- Defined: wr_data widens to 2W_DATA+1 bits; the MSB is even parity over {real,imag}, computed in S2 with no added latency.
- Undefined: wr_data is exactly 2W_DATA bits with no parity logic.

Decomposition:
- Package mrd_pkg holds: N_LANE, W_DATA, W_ADDR, W_IDX, the factor encoding constants, the FSM state enum (IDLE/RUN/FLUSH/DONE), and the err bit position constants.
- One sub-module, mrd_bank_sel: combinational per-bank lane selector (priority encode plus conflict detect), instantiated N_LANE times.

Test Plan:
- Factor 5, n_beats=4, lane i → bank (i+k)%5 at addr k (k = beat number) → 20 writes, each bank hit once per beat; wr_en=5'b11111 at t+2. done 1 cycle after FLUSH; err=0; exp_out=in_exp (e.g. 4'd3).
- Factor 3, lanes 3-4 carry junk indices → only 3 banks written per beat; err=0.
- Factor 4, lanes 1 and 2 both → bank 2 → bank 2 gets lane 1's data; err[0]=1 and stays set until the next sop.
- Lane 0 index=6, factor 5 → lane 0 dropped; err[1]=1; other lanes written normally.
- sop at beat 2 of n_beats=8 → counter restarts; stage completes after 8 further beats; err=3'b100.
- rst asserted mid-RUN → wr_en, busy, done=0 immediately; the next sop with n_beats=1 completes normally. With MRD_BANK_WR_PARITY_EN defined, data 0x00001/0x00000 → parity bit 1.
